// File: rtl/sseg_scan_driver_if.sv
// Display-side bundle for sseg_scan_driver: load/value/mode in, status and pin pattern out.
interface sseg_scan_driver_if;
    logic [15:0] value;
    logic        load;
    logic        dec;
    logic        blank_lz;
    logic        busy;
    logic        ovf;
    logic [6:0]  Segments;
    logic [3:0]  Anodes;

    modport master (output value, load, dec, blank_lz,
                    input  busy, ovf, Segments, Anodes);
    modport slave  (input  value, load, dec, blank_lz,
                    output busy, ovf, Segments, Anodes);
endinterface

// File: rtl/sseg_scan_driver.sv
// 4-digit multiplexed 7-segment driver; hex or decimal (sequential double-dabble) display,
// with optional leading-zero blanking.
module sseg_scan_driver #(
    parameter int DIGIT_CYCLES = 4,
    parameter int CONV_BITS    = 16
) (
    input  logic               clk,
    input  logic               reset,
    sseg_scan_driver_if.slave  bus
);
    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_CYCLES - 1);
    localparam logic [4:0]    ITER_LAST  = 5'(CONV_BITS - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t           state_q;
    logic [3:0][3:0]  digits_q;
    logic             ovf_q;
    logic             busy_q;
    logic [1:0]       idx_q, idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [15:0]      bin_q, bin_d;
    logic [19:0]      bcd_q, bcd_d, bcd_adj;
    logic [4:0]       iter_q;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q;
    logic             allz_d, blank_d;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Scan position and the glyph for the digit that will be lit after this edge.
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        idx_d   = idx_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = idx_q + 2'd1;
        end
        allz_d = 1'b1;
        for (int k = 0; k < 4; k++)
            if (k >= int'(idx_d) && digits_q[k] != 4'h0) allz_d = 1'b0;
        blank_d = bus.blank_lz && (idx_d != 2'd0) && allz_d;
        seg_d   = blank_d ? 7'b1111111 : glyph(digits_q[idx_d]);
    end

    // One double-dabble iteration: add 3 to any BCD digit >= 5, then shift in the next bit.
    always_comb begin
        for (int i = 0; i < 5; i++)
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                          : bcd_q[i*4 +: 4];
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            idx_q    <= 2'd0;
            dwell_q  <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            seg_q    <= 7'b1000000;
            an_q     <= 4'b1110;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= ~(4'b0001 << idx_d);
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        if (bus.dec) begin
                            bin_q   <= bus.value;
                            bcd_q   <= '0;
                            iter_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_CONV;
                        end else begin
                            digits_q <= bus.value;
                        end
                    end
                end
                S_CONV: begin
                    bin_q  <= bin_d;
                    bcd_q  <= bcd_d;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == ITER_LAST) begin
                        digits_q <= bcd_d[15:0];
                        ovf_q    <= |bcd_d[19:16];
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.ovf      = ovf_q;
    assign bus.Segments = seg_q;
    assign bus.Anodes   = an_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: per-cycle reference model, table of display vectors,
// abort/ignore corner sequence and randomized traffic.
module tb_sseg_scan_driver;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sseg_scan_driver_if bus();

    sseg_scan_driver #(.DIGIT_CYCLES(DC), .CONV_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [6:0] GLY [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    int          t;
    logic [3:0]  m_dig [4];
    bit          m_busy;
    int          m_cnt;
    int          m_pend;
    bit          m_ovf;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;

    typedef struct {
        logic [15:0]     value;
        logic            dec;
        logic            blank;
        logic [6:0]      seg [4];
        logic            ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behaviour at one rising edge, from the inputs present before it.
    task automatic model_edge();
        int  k;
        bit  allz;
        int  v;
        if (reset) begin
            t = 0;
            for (int j = 0; j < 4; j++) m_dig[j] = 4'h0;
            m_busy = 0; m_cnt = 0; m_ovf = 0;
            e_an  = 4'b1110;
            e_seg = 7'b1000000;
        end else begin
            t++;
            k = (t / DC) % 4;
            e_an = ~(4'b0001 << k);
            allz = 1;
            for (int j = k; j < 4; j++) if (m_dig[j] != 4'h0) allz = 0;
            e_seg = (bus.blank_lz && k > 0 && allz) ? 7'b1111111 : GLY[m_dig[k]];
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    v = m_pend % 10000;
                    m_dig[0] = 4'(v % 10);
                    m_dig[1] = 4'((v / 10) % 10);
                    m_dig[2] = 4'((v / 100) % 10);
                    m_dig[3] = 4'((v / 1000) % 10);
                    m_ovf = (m_pend > 9999);
                end
            end else if (bus.load) begin
                if (bus.dec) begin
                    m_busy = 1; m_cnt = 16; m_pend = int'(bus.value);
                end else begin
                    for (int j = 0; j < 4; j++) m_dig[j] = bus.value[j*4 +: 4];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("anodes",   32'(bus.Anodes),   32'(e_an));
        chk("segments", 32'(bus.Segments), 32'(e_seg));
        chk("busy",     32'(bus.busy),     32'(m_busy));
        chk("ovf",      32'(bus.ovf),      32'(m_ovf));
    endtask

    task automatic run_vec(input vec_t v);
        int bc, n;
        logic [3:0] seen;
        bus.value = v.value; bus.dec = v.dec; bus.blank_lz = v.blank; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        if (v.dec) begin
            bc = bus.busy ? 1 : 0;
            n = 0;
            while (bus.busy === 1'b1 && n < 40) begin
                step();
                n++;
                if (bus.busy === 1'b1) bc++;
            end
            chk("busy_timeout", 32'(n < 40), 32'd1);
            chk("busy_len", 32'(bc), 32'd16);
        end
        seen = 4'h0;
        for (int c = 0; c < 5 * DC; c++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (bus.Anodes === ~(4'b0001 << k)) begin
                    chk($sformatf("tbl_seg%0d_%h", k, v.value), 32'(bus.Segments), 32'(v.seg[k]));
                    seen[k] = 1'b1;
                end
            end
        end
        chk("tbl_all_digits_seen", 32'(seen), 32'hF);
        chk("tbl_ovf", 32'(bus.ovf), 32'(v.ovf));
    endtask

    initial begin
        tbl[0] = '{16'hA5C3, 1'b0, 1'b0, '{7'b0110000, 7'b1000110, 7'b0010010, 7'b0001000}, 1'b0};
        tbl[1] = '{16'd1234, 1'b1, 1'b0, '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 1'b0};
        tbl[2] = '{16'd65535, 1'b1, 1'b0, '{7'b0010010, 7'b0110000, 7'b0010010, 7'b0010010}, 1'b1};
        tbl[3] = '{16'h0007, 1'b0, 1'b0, '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000}, 1'b1};
        tbl[4] = '{16'h0040, 1'b0, 1'b1, '{7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111}, 1'b1};
        tbl[5] = '{16'h0000, 1'b0, 1'b1, '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111}, 1'b1};
        tbl[6] = '{16'd9999, 1'b1, 1'b0, '{7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}, 1'b0};
        tbl[7] = '{16'd10000, 1'b1, 1'b1, '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111}, 1'b1};

        reset = 1'b1;
        bus.value = '0; bus.load = 1'b0; bus.dec = 1'b0; bus.blank_lz = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rst_anodes",   32'(bus.Anodes),   32'(4'b1110));
        chk("rst_segments", 32'(bus.Segments), 32'(7'b1000000));
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_ovf",      32'(bus.ovf),      32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8 * DC; i++) step();

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Decimal 9999 interrupted: load while busy ignored, then reset aborts.
        bus.value = 16'd9999; bus.dec = 1'b1; bus.blank_lz = 1'b0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.value = 16'h1111; bus.dec = 1'b0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("ignored_load_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        chk("abort_busy",     32'(bus.busy),     32'd0);
        chk("abort_ovf",      32'(bus.ovf),      32'd0);
        chk("abort_anodes",   32'(bus.Anodes),   32'(4'b1110));
        chk("abort_segments", 32'(bus.Segments), 32'(7'b1000000));
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("no_9999_glyph", 32'(bus.Segments == 7'b0010000), 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            bus.load  = ($urandom_range(0, 9) == 0);
            bus.dec   = 1'($urandom_range(0, 1));
            bus.value = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12000)) : 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            step();
        end
        reset = 1'b0;
        bus.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
